// File: rtl/pipe_control_pkg.sv
// Shared constants and types for the pipeline control slice.
// Optional mul/div support is enabled by defining PIPE_CONTROL_MULDIV_EN.
package pipe_control_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_IMM    = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  // ALUOp encodings handed to the EX-stage ALU control
  localparam logic [1:0] ALU_OP_IMM = 2'b00;
  localparam logic [1:0] ALU_OP_REG = 2'b10;

  // Funct7 value that marks an OP instruction as multiply/divide
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Control bundle; the field order fixes the bundle bit positions
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic mul_div;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Mul/div sequencer states
  typedef enum logic {
    CTRL_IDLE = 1'b0,
    CTRL_BUSY = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipe_control_ctrl_decode.sv
// Purely combinational ID-stage decoder: opcode/funct7 -> control bundle,
// source-register usage flags and an illegal-instruction flag.
// With PIPE_CONTROL_MULDIV_EN undefined, OP with the mul/div funct7 is illegal.
module pipe_control_ctrl_decode
  import pipe_control_pkg::*;
#(
  parameter int ALUOP_W = 2
) (
  input  logic [6:0]         opcode_i,
  input  logic [6:0]         funct7_i,
  output ctrl_t              ctrl_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic               use_rs1_o,
  output logic               use_rs2_o,
  output logic               illegal_o
);

`ifdef PIPE_CONTROL_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  logic is_muldiv;
  assign is_muldiv = (funct7_i == FUNCT7_MULDIV);

  // Decode table; every output defaults to 0 so nothing is ever left undriven
  always_comb begin
    ctrl_o    = CTRL_NONE;
    alu_op_o  = '0;
    use_rs1_o = 1'b0;
    use_rs2_o = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OPCODE_OP: begin
        if (is_muldiv && !MULDIV_EN) begin
          illegal_o = 1'b1;
        end else begin
          ctrl_o.reg_write = 1'b1;
          ctrl_o.mul_div   = is_muldiv;
          alu_op_o         = ALUOP_W'(ALU_OP_REG);
          use_rs1_o        = 1'b1;
          use_rs2_o        = 1'b1;
        end
      end
      OPCODE_IMM: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        alu_op_o         = ALUOP_W'(ALU_OP_IMM);
        use_rs1_o        = 1'b1;
      end
      OPCODE_LOAD: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.mem_read   = 1'b1;
        ctrl_o.alu_src    = 1'b1;
        alu_op_o          = ALUOP_W'(ALU_OP_IMM);
        use_rs1_o         = 1'b1;
      end
      OPCODE_STORE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        alu_op_o         = ALUOP_W'(ALU_OP_IMM);
        use_rs1_o        = 1'b1;
        use_rs2_o        = 1'b1;
      end
      OPCODE_BRANCH: begin
        ctrl_o.branch = 1'b1;
        alu_op_o      = ALUOP_W'(ALU_OP_REG);
        use_rs1_o     = 1'b1;
        use_rs2_o     = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_control.sv
// Pipelined control unit: decodes the ID instruction, carries the control
// bundle through ID/EX, EX/MEM and MEM/WB, and raises stall/flush for
// load-use hazards, taken branches and multi-cycle mul/div.
// Define PIPE_CONTROL_MULDIV_EN to enable mul/div decode and the BUSY sequencer.
//
// Handshake: Stall_o=1 means the front end must hold PC and IF/ID this cycle;
// Flush_o=1 means IF/ID is squashed. Valid_i marks IF/ID as a real instruction;
// every stage *Valid_o marks its bundle as real, a bubble is Valid=0 with all
// control bits and Rd zero.
module pipe_control
  import pipe_control_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Valid_i,
  input  logic [6:0]            Opcode_i,
  input  logic [6:0]            Funct7_i,
  input  logic [REG_ADDR_W-1:0] Rs1_i,
  input  logic [REG_ADDR_W-1:0] Rs2_i,
  input  logic [REG_ADDR_W-1:0] Rd_i,
  input  logic                  BranchTaken_i,
  output logic                  Stall_o,
  output logic                  Flush_o,
  output logic                  Illegal_o,
  output logic                  ExValid_o,
  output logic [ALUOP_W-1:0]    ExALUOp_o,
  output logic                  ExALUSrc_o,
  output logic                  ExBranch_o,
  output logic                  ExMulDiv_o,
  output logic [REG_ADDR_W-1:0] ExRd_o,
  output logic                  MemValid_o,
  output logic                  MemRead_o,
  output logic                  MemWrite_o,
  output logic [REG_ADDR_W-1:0] MemRd_o,
  output logic                  WbValid_o,
  output logic                  WbRegWrite_o,
  output logic                  WbMemToReg_o,
  output logic [REG_ADDR_W-1:0] WbRd_o
);

  // ID-stage decode
  ctrl_t                  id_ctrl;
  logic [ALUOP_W-1:0]     id_alu_op;
  logic                   id_use_rs1;
  logic                   id_use_rs2;
  logic                   id_illegal;
  logic                   id_ok;
  logic [REG_ADDR_W-1:0]  id_rd;

  pipe_control_ctrl_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .opcode_i  (Opcode_i),
    .funct7_i  (Funct7_i),
    .ctrl_o    (id_ctrl),
    .alu_op_o  (id_alu_op),
    .use_rs1_o (id_use_rs1),
    .use_rs2_o (id_use_rs2),
    .illegal_o (id_illegal)
  );

  assign id_ok     = Valid_i & ~id_illegal;
  // Rd is meaningful only for register writers; otherwise drive 0
  assign id_rd     = id_ctrl.reg_write ? Rd_i : '0;
  assign Illegal_o = Valid_i & id_illegal;

  // Stage registers
  logic                  ex_valid_q, ex_valid_d;
  ctrl_t                 ex_ctrl_q, ex_ctrl_d;
  logic [ALUOP_W-1:0]    ex_alu_op_q, ex_alu_op_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;

  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_reg_write_q, mem_reg_write_d;
  logic                  mem_mem_to_reg_q, mem_mem_to_reg_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;

  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic                  wb_mem_to_reg_q, wb_mem_to_reg_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;

  // Hazard terms
  logic flush;
  logic busy;
  logic load_use;
  logic stall;
  logic ex_hold;
  logic id_to_ex;

  assign flush = BranchTaken_i & ex_valid_q & ex_ctrl_q.branch;

  // x0 is never a real producer, so ExRd==0 cannot create a hazard
  assign load_use = Valid_i & ex_valid_q & ex_ctrl_q.mem_read & (ex_rd_q != '0) &
                    ((id_use_rs1 & (Rs1_i == ex_rd_q)) |
                     (id_use_rs2 & (Rs2_i == ex_rd_q)));

  // Event priority: flush > mul/div busy > load-use > normal advance
  always_comb begin
    stall    = 1'b0;
    ex_hold  = 1'b0;
    id_to_ex = 1'b0;
    if (!flush) begin
      if (busy) begin
        ex_hold = 1'b1;
        stall   = 1'b1;
      end else if (load_use) begin
        stall = 1'b1;
      end else begin
        id_to_ex = id_ok;
      end
    end
  end

  assign Stall_o = ~rst_i & stall;
  assign Flush_o = ~rst_i & flush;

`ifdef PIPE_CONTROL_MULDIV_EN
  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign busy       = (state_q == CTRL_BUSY);
  assign ExMulDiv_o = ex_ctrl_q.mul_div;

  // Mul/div sequencer state and remaining-cycle counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CTRL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Enter BUSY as a mul/div lands in EX; leave after the counter reaches 1
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CTRL_IDLE: begin
        if (id_to_ex && id_ctrl.mul_div && (MULDIV_LAT > 1)) begin
          state_d = CTRL_BUSY;
          cnt_d   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      CTRL_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = CTRL_IDLE;
        end
      end
      default: begin
        state_d = CTRL_IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`else
  logic unused_mul_div;
  assign busy           = 1'b0;
  assign ExMulDiv_o     = 1'b0;
  assign unused_mul_div = ex_ctrl_q.mul_div;
`endif

  // Next contents of each stage register
  always_comb begin
    ex_valid_d  = 1'b0;
    ex_ctrl_d   = CTRL_NONE;
    ex_alu_op_d = '0;
    ex_rd_d     = '0;
    if (ex_hold) begin
      ex_valid_d  = ex_valid_q;
      ex_ctrl_d   = ex_ctrl_q;
      ex_alu_op_d = ex_alu_op_q;
      ex_rd_d     = ex_rd_q;
    end else if (id_to_ex) begin
      ex_valid_d  = 1'b1;
      ex_ctrl_d   = id_ctrl;
      ex_alu_op_d = id_alu_op;
      ex_rd_d     = id_rd;
    end

    mem_valid_d      = 1'b0;
    mem_reg_write_d  = 1'b0;
    mem_mem_to_reg_d = 1'b0;
    mem_read_d       = 1'b0;
    mem_write_d      = 1'b0;
    mem_rd_d         = '0;
    if (!ex_hold) begin
      mem_valid_d      = ex_valid_q;
      mem_reg_write_d  = ex_ctrl_q.reg_write;
      mem_mem_to_reg_d = ex_ctrl_q.mem_to_reg;
      mem_read_d       = ex_ctrl_q.mem_read;
      mem_write_d      = ex_ctrl_q.mem_write;
      mem_rd_d         = ex_rd_q;
    end

    wb_valid_d      = mem_valid_q;
    wb_reg_write_d  = mem_reg_write_q;
    wb_mem_to_reg_d = mem_mem_to_reg_q;
    wb_rd_d         = mem_rd_q;
  end

  // ID/EX, EX/MEM and MEM/WB registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_q       <= 1'b0;
      ex_ctrl_q        <= CTRL_NONE;
      ex_alu_op_q      <= '0;
      ex_rd_q          <= '0;
      mem_valid_q      <= 1'b0;
      mem_reg_write_q  <= 1'b0;
      mem_mem_to_reg_q <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_rd_q         <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_mem_to_reg_q  <= 1'b0;
      wb_rd_q          <= '0;
    end else begin
      ex_valid_q       <= ex_valid_d;
      ex_ctrl_q        <= ex_ctrl_d;
      ex_alu_op_q      <= ex_alu_op_d;
      ex_rd_q          <= ex_rd_d;
      mem_valid_q      <= mem_valid_d;
      mem_reg_write_q  <= mem_reg_write_d;
      mem_mem_to_reg_q <= mem_mem_to_reg_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_rd_q         <= mem_rd_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_mem_to_reg_q  <= wb_mem_to_reg_d;
      wb_rd_q          <= wb_rd_d;
    end
  end

  assign ExValid_o    = ex_valid_q;
  assign ExALUOp_o    = ex_alu_op_q;
  assign ExALUSrc_o   = ex_ctrl_q.alu_src;
  assign ExBranch_o   = ex_ctrl_q.branch;
  assign ExRd_o       = ex_rd_q;
  assign MemValid_o   = mem_valid_q;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign MemRd_o      = mem_rd_q;
  assign WbValid_o    = wb_valid_q;
  assign WbRegWrite_o = wb_reg_write_q;
  assign WbMemToReg_o = wb_mem_to_reg_q;
  assign WbRd_o       = wb_rd_q;

endmodule

// File: doc/pipe_control.md
Name: pipe_control

Overview:
- Parametrised pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage instruction and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers.
- Generates stall and flush for:
  - load-use hazards;
  - taken branches;
  - multi-cycle multiply/divide ops.
- Sits between the IF/ID register and the datapath stage registers; the datapath consumes the per-stage outputs directly.

Parameters:
- REG_ADDR_W, 5, register index width.
- ALUOP_W, 2, ALUOp field width.
- MULDIV_LAT, 4, EX-stage cycles a mul/div occupies (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Valid_i  in  1  IF/ID holds a real instruction.
- Opcode_i  in  7  instruction[6:0].
- Funct7_i  in  7  instruction[31:25].
- Rs1_i  in  REG_ADDR_W  source register 1.
- Rs2_i  in  REG_ADDR_W  source register 2.
- Rd_i  in  REG_ADDR_W  destination register.
- BranchTaken_i  in  1  EX-stage branch resolved taken.
- Stall_o  out  1  hold PC and IF/ID.
- Flush_o  out  1  clear IF/ID.
- Illegal_o  out  1  ID instruction undecodable (combinational, qualified by Valid_i).
- ExValid_o, ExALUOp_o[ALUOP_W], ExALUSrc_o, ExBranch_o, ExMulDiv_o, ExRd_o[REG_ADDR_W]  out  EX-stage bundle.
- MemValid_o, MemRead_o, MemWrite_o, MemRd_o[REG_ADDR_W]  out  MEM-stage bundle.
- WbValid_o, WbRegWrite_o, WbMemToReg_o, WbRd_o[REG_ADDR_W]  out  WB-stage bundle.

Behaviour:
- **Decode (combinational, ID)**
  - OP: RegWrite, ALUOp=REG, uses rs1 and rs2.
  - IMM: RegWrite, ALUSrc, ALUOp=IMM, uses rs1.
  - LOAD: RegWrite, MemToReg, MemRead, ALUSrc, ALUOp=IMM, uses rs1.
  - STORE: MemWrite, ALUSrc, ALUOp=IMM, uses rs1 and rs2.
  - BRANCH: Branch, ALUOp=REG, uses rs1 and rs2.
  - OP with Funct7=0000001: MulDiv=1.
  - Any other opcode: Illegal_o=1, bundle all-zero.
  - No x is ever driven; don't-care fields are driven 0.
- **Bubble**: Valid=0 with every control bit 0 and Rd=0.
- **Reset**
  - All registered outputs 0; Stall_o=0, Flush_o=0.
  - FSM to IDLE; counter to 0.
  - Reset asserted mid mul/div aborts it with no residual stall.
- **Normal advance (1 cycle/stage)**
  - ID bundle -> EX -> MEM -> WB on each clk_i.
  - Illegal or !Valid_i enters EX as a bubble.
- **Load-use stall**
  - Condition: ExValid & MemRead_of_EX & ExRd!=0 & ((rs1 used & Rs1_i==ExRd) | (rs2 used & Rs2_i==ExRd)) & Valid_i.
  - Response: Stall_o=1 for exactly 1 cycle; a bubble enters EX; EX advances normally.
- **Mul/div FSM** (states IDLE, BUSY)
  - IDLE -> BUSY when a MulDiv op enters EX and MULDIV_LAT>1; counter loads MULDIV_LAT-1.
  - While BUSY:
    - EX holds its contents and Stall_o=1;
    - MEM receives a bubble each cycle;
    - counter decrements.
  - BUSY -> IDLE when counter==1.
  - The op moves to MEM on the cycle after the last BUSY cycle.
  - Total EX occupancy = MULDIV_LAT cycles.
  - MULDIV_LAT=1 behaves as a normal ALU op.
- **Branch flush**
  - BranchTaken_i with ExValid & ExBranch gives Flush_o=1 and the ID bundle enters EX as a bubble.
  - Stall_o=0 that cycle.
  - BranchTaken_i while EX is not a valid branch is ignored.
- **Priority** (simultaneous events): rst_i > branch flush > mul/div BUSY > load-use.
  - A load-use coinciding with a flush is dropped, since the ID instruction is squashed.
- **Load-use during BUSY**: not evaluated; EX holds a non-load.
- **x0 writes**: Rd=0 never triggers a hazard.

Optional Feature:
- Macro: PIPE_CONTROL_MULDIV_EN.
- Defined:
  - Funct7=0000001 on OP decodes as MulDiv;
  - BUSY FSM and counter are present.
- Undefined:
  - OP with Funct7=0000001 raises Illegal_o and enters EX as a bubble;
  - no FSM or counter logic;
  - ExMulDiv_o tied 0.

Decomposition:
- **Const.v** (shared include)
  - OPCODE_* and ALU_OP_* codes;
  - FUNCT7_MULDIV;
  - bundle bit positions for the EX/MEM/WB fields;
  - FSM state encodings CTRL_IDLE and CTRL_BUSY.
- **Sub-module ctrl_decode** (purely combinational)
  - Opcode/Funct7 -> bundle, rs-used flags and Illegal.
  - Reused later by a multi-issue front end.
- **pipe_control** owns:
  - the stage registers;
  - hazard logic;
  - the mul/div FSM.

Test Plan:
- **Reset**: assert rst_i with valid LOAD in ID -> next cycle all outputs 0. Release -> LOAD reaches ExValid_o=1 one cycle later, MemRead_o at +2, WbMemToReg_o at +3.
- **Load-use**: LOAD rd=5 in EX, ID=OP rs1=5 -> Stall_o=1 for one cycle, bubble in EX. Next cycle OP enters EX.
- **x0 case**: LOAD rd=0, then OP rs2=0 -> no stall.
- **Branch flush**: BRANCH in EX with BranchTaken_i=1, ID=STORE -> Flush_o=1, next ExValid_o=0, MemWrite_o never asserts for that STORE.
- **Mul/div** (PIPE_CONTROL_MULDIV_EN, MULDIV_LAT=4): OP Funct7=0000001 rd=7 -> ExMulDiv_o held 4 cycles, Stall_o=1 for 3, MemValid_o=0 for those 3 cycles, then MemRd_o=7.
  - Assert rst_i in BUSY cycle 2 -> Stall_o=0 next cycle.
- **Without PIPE_CONTROL_MULDIV_EN**: same instruction -> Illegal_o=1, ExValid_o=0, Stall_o never 1.
- **Undefined opcode 7'b1111111**: Illegal_o=1 -> bubble propagates and WbRegWrite_o stays 0.
